// File: rtl/id_hazard_forward_unit_pkg.sv
// Shared definitions for the ID-stage hazard detection and forwarding unit:
// forwarding-mux select codes and the stall controller state encoding.
package id_hazard_forward_unit_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_IDEX  = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/id_hazard_forward_unit_fwd_src_match.sv
// Per-operand producer matching: forwarding select code and the number of
// stall cycles this operand needs before its data can be consumed in ID.
module fwd_src_match
  import id_hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  used_i,
  input  logic                  is_branch_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
  input  logic                  id_ex_regwrite_i,
  input  logic                  id_ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd_i,
  input  logic                  ex_mem_regwrite_i,
  input  logic                  ex_mem_memread_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_regwrite_i,
  output logic [1:0]            fwd_sel_o,
  output logic [1:0]            req_o
);

  logic match_idex;
  logic match_exmem;
  logic match_wb;

  // Register 0 is hardwired, so a write to it is never a real producer.
  assign match_idex  = (id_ex_rd_i  == src_i) && (id_ex_rd_i  != '0) && id_ex_regwrite_i  && used_i;
  assign match_exmem = (ex_mem_rd_i == src_i) && (ex_mem_rd_i != '0) && ex_mem_regwrite_i && used_i;
  assign match_wb    = (wb_rd_i     == src_i) && (wb_rd_i     != '0) && wb_regwrite_i     && used_i;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    fwd_sel_o = FWD_REG;
    if (match_idex)       fwd_sel_o = FWD_IDEX;
    else if (match_exmem) fwd_sel_o = FWD_EXMEM;
    else if (match_wb)    fwd_sel_o = FWD_WB;
  end

  always_comb begin
    req_o = 2'd0;
    if (is_branch_i) begin
      if (match_idex && id_ex_memread_i)         req_o = 2'd2;
      else if (match_exmem && ex_mem_memread_i)  req_o = 2'd1;
    end else if (match_idex && id_ex_memread_i) begin
      req_o = 2'd1;
    end
  end

endmodule

// File: rtl/id_hazard_forward_unit.sv
// ID-stage forwarding control with load-use stall sequencing: per-source
// matching, worst-case stall reduction, IDLE/STALL controller and stall statistics.
module id_hazard_forward_unit
  import id_hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int STAT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]            id_src_used_i,
  input  logic                          id_is_branch_i,
  input  logic                          id_flush_i,
  input  logic [REG_ADDR_W-1:0]         id_ex_rd_i,
  input  logic                          id_ex_regwrite_i,
  input  logic                          id_ex_memread_i,
  input  logic [REG_ADDR_W-1:0]         ex_mem_rd_i,
  input  logic                          ex_mem_regwrite_i,
  input  logic                          ex_mem_memread_i,
  input  logic [REG_ADDR_W-1:0]         wb_rd_i,
  input  logic                          wb_regwrite_i,
  input  logic                          stat_clr_i,
  output logic [NUM_SRC*2-1:0]          fwd_sel_o,
  output logic                          stall_o,
  output logic [STAT_W-1:0]             stall_cycles_o
);

  logic [NUM_SRC-1:0][1:0] req;
  logic [1:0]              need;
  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [STAT_W-1:0]       stall_cycles_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
      .src_i             (id_src_i[g*REG_ADDR_W +: REG_ADDR_W]),
      .used_i            (id_src_used_i[g]),
      .is_branch_i       (id_is_branch_i),
      .id_ex_rd_i        (id_ex_rd_i),
      .id_ex_regwrite_i  (id_ex_regwrite_i),
      .id_ex_memread_i   (id_ex_memread_i),
      .ex_mem_rd_i       (ex_mem_rd_i),
      .ex_mem_regwrite_i (ex_mem_regwrite_i),
      .ex_mem_memread_i  (ex_mem_memread_i),
      .wb_rd_i           (wb_rd_i),
      .wb_regwrite_i     (wb_regwrite_i),
      .fwd_sel_o         (fwd_sel_o[g*2 +: 2]),
      .req_o             (req[g])
    );
  end

  always_comb begin
    need = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i] > need) need = req[i];
    end
  end

  // Detection only arms the controller from IDLE; once stalling, cnt alone
  // decides when the stall ends, and a flush aborts it in any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = (need != 2'd0) && !id_flush_i;
        if (stall_o) begin
          cnt_d   = need - 2'd1;
          state_d = (need != 2'd1) ? STALL : IDLE;
        end
      end
      STALL: begin
        stall_o = !id_flush_i;
        if ((cnt_q == 2'd1) || id_flush_i) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (stat_clr_i) begin
      stall_cycles_q <= '0;
    end else if (stall_o && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Scoreboard bench: the driver pushes expected responses from a pipeline-level
// reference model; a monitor pops and compares one entry per driven cycle.
module tb_id_hazard_forward_unit;

  localparam int RW = 3;
  localparam int NS = 2;
  localparam int SW = 4;
  localparam int SAT = (1 << SW) - 1;

  typedef struct {
    logic [RW-1:0] src0, src1;
    logic [1:0]    used;
    logic          branch, flush, clr;
    logic [RW-1:0] idex_rd, exmem_rd, wb_rd;
    logic          idex_rw, idex_mr, exmem_rw, exmem_mr, wb_rw;
  } in_t;

  typedef struct {
    logic [3:0] fwd;
    logic       stall;
    logic [3:0] sc;
  } exp_t;

  logic              clk, rst_n;
  logic [NS*RW-1:0]  id_src;
  logic [NS-1:0]     id_src_used;
  logic              id_is_branch, id_flush, stat_clr;
  logic [RW-1:0]     id_ex_rd, ex_mem_rd, wb_rd;
  logic              id_ex_regwrite, id_ex_memread, ex_mem_regwrite, ex_mem_memread, wb_regwrite;
  logic [NS*2-1:0]   fwd_sel;
  logic              stall;
  logic [SW-1:0]     stall_cycles;

  id_hazard_forward_unit #(.REG_ADDR_W(RW), .NUM_SRC(NS), .STAT_W(SW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_src_i          (id_src),
    .id_src_used_i     (id_src_used),
    .id_is_branch_i    (id_is_branch),
    .id_flush_i        (id_flush),
    .id_ex_rd_i        (id_ex_rd),
    .id_ex_regwrite_i  (id_ex_regwrite),
    .id_ex_memread_i   (id_ex_memread),
    .ex_mem_rd_i       (ex_mem_rd),
    .ex_mem_regwrite_i (ex_mem_regwrite),
    .ex_mem_memread_i  (ex_mem_memread),
    .wb_rd_i           (wb_rd),
    .wb_regwrite_i     (wb_regwrite),
    .stat_clr_i        (stat_clr),
    .fwd_sel_o         (fwd_sel),
    .stall_o           (stall),
    .stall_cycles_o    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   stall_left = 0;
  int   sc_model   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic in_t quiet();
    in_t x;
    x.src0 = '0; x.src1 = '0; x.used = '0;
    x.branch = 0; x.flush = 0; x.clr = 0;
    x.idex_rd = '0; x.exmem_rd = '0; x.wb_rd = '0;
    x.idex_rw = 0; x.idex_mr = 0; x.exmem_rw = 0; x.exmem_mr = 0; x.wb_rw = 0;
    return x;
  endfunction

  // Reference: a source matches the youngest in-flight writer of its register;
  // the stall need is how many cycles until a load's data reaches where ID can use it.
  function automatic void model_comb(input in_t x, output logic [3:0] fwd, output int need);
    logic [RW-1:0] rd[3];
    logic          rw[3];
    logic          m[3];
    logic [RW-1:0] src;
    int            code, req;
    rd[0] = x.idex_rd;  rw[0] = x.idex_rw;
    rd[1] = x.exmem_rd; rw[1] = x.exmem_rw;
    rd[2] = x.wb_rd;    rw[2] = x.wb_rw;
    need = 0;
    fwd  = '0;
    for (int s = 0; s < NS; s++) begin
      src  = (s == 0) ? x.src0 : x.src1;
      code = 0;
      for (int k = 2; k >= 0; k--) begin
        m[k] = x.used[s] && rw[k] && (rd[k] != 0) && (rd[k] == src);
        if (m[k]) code = k + 1;
      end
      fwd[s*2 +: 2] = code[1:0];
      req = 0;
      if (m[0] && x.idex_mr)                     req = x.branch ? 2 : 1;
      else if (x.branch && m[1] && x.exmem_mr)   req = 1;
      if (req > need) need = req;
    end
  endfunction

  task automatic apply(input in_t x);
    id_src          = {x.src1, x.src0};
    id_src_used     = x.used;
    id_is_branch    = x.branch;
    id_flush        = x.flush;
    stat_clr        = x.clr;
    id_ex_rd        = x.idex_rd;  id_ex_regwrite  = x.idex_rw;  id_ex_memread  = x.idex_mr;
    ex_mem_rd       = x.exmem_rd; ex_mem_regwrite = x.exmem_rw; ex_mem_memread = x.exmem_mr;
    wb_rd           = x.wb_rd;    wb_regwrite     = x.wb_rw;
  endtask

  task automatic drive(input in_t x);
    exp_t       e;
    logic [3:0] fwd;
    int         need;
    @(negedge clk);
    apply(x);
    model_comb(x, fwd, need);
    e.fwd   = fwd;
    e.stall = x.flush ? 1'b0 : ((stall_left > 0) ? 1'b1 : (need != 0));
    e.sc    = sc_model[3:0];
    exp_q.push_back(e);
    if (x.flush)             stall_left = 0;
    else if (stall_left > 0) stall_left--;
    else if (need > 0)       stall_left = need - 1;
    if (x.clr)                       sc_model = 0;
    else if (e.stall && sc_model < SAT) sc_model++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_sel", 32'(fwd_sel), 32'(e.fwd));
        check("stall", 32'(stall), 32'(e.stall));
        check("stall_cycles", 32'(stall_cycles), 32'(e.sc));
      end
    end
  end

  initial begin : stimulus
    in_t x;
    rst_n = 1'b0;
    apply(quiet());
    #3;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_fwd_sel", 32'(fwd_sel), 32'd0);
    check("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding priority: ID/EX ALU result wins over EX/MEM for the same register.
    x = quiet();
    x.idex_rd = 3; x.idex_rw = 1; x.exmem_rd = 3; x.exmem_rw = 1;
    x.src0 = 3; x.used = 2'b01; x.branch = 1;
    drive(x);

    // Branch after load: load advances ID/EX -> EX/MEM -> WB across a 2-cycle stall.
    x = quiet(); x.clr = 1; drive(x);
    x = quiet();
    x.src0 = 2; x.used = 2'b01; x.branch = 1;
    x.idex_rd = 2; x.idex_rw = 1; x.idex_mr = 1;
    drive(x);
    x.idex_rw = 0; x.idex_mr = 0; x.idex_rd = 0;
    x.exmem_rd = 2; x.exmem_rw = 1; x.exmem_mr = 1;
    drive(x);
    x.exmem_rd = 0; x.exmem_rw = 0; x.exmem_mr = 0;
    x.wb_rd = 2; x.wb_rw = 1;
    drive(x);
    drive(quiet());

    // Non-branch after load, then branch behind a load sitting in EX/MEM.
    x = quiet();
    x.src1 = 5; x.used = 2'b10;
    x.idex_rd = 5; x.idex_rw = 1; x.idex_mr = 1;
    drive(x);
    x.idex_rd = 0; x.idex_rw = 0; x.idex_mr = 0;
    x.exmem_rd = 5; x.exmem_rw = 1; x.exmem_mr = 1;
    drive(x);
    x.branch = 1;
    drive(x);
    x.exmem_rd = 0; x.exmem_rw = 0; x.exmem_mr = 0; x.wb_rd = 5; x.wb_rw = 1;
    drive(x);

    // Register 0 and unused sources never match.
    x = quiet();
    x.branch = 1; x.used = 2'b11;
    x.idex_rd = 0; x.idex_rw = 1; x.idex_mr = 1;
    drive(x);
    x = quiet();
    x.branch = 1; x.src0 = 4; x.used = 2'b00;
    x.idex_rd = 4; x.idex_rw = 1; x.idex_mr = 1;
    drive(x);

    // Flush in the second cycle of a 2-cycle stall.
    x = quiet(); x.clr = 1; drive(x);
    x = quiet();
    x.src0 = 2; x.used = 2'b01; x.branch = 1;
    x.idex_rd = 2; x.idex_rw = 1; x.idex_mr = 1;
    drive(x);
    x.flush = 1;
    drive(x);
    drive(quiet());
    drive(quiet());

    // Saturation of the 4-bit counter, then clear while stalling.
    x = quiet();
    x.src0 = 6; x.used = 2'b01;
    x.idex_rd = 6; x.idex_rw = 1; x.idex_mr = 1;
    for (int i = 0; i < 20; i++) drive(x);
    x.clr = 1;
    drive(x);
    drive(quiet());

    // Randomised traffic over a small register range so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      x.src0     = RW'($urandom_range(0, 3));
      x.src1     = RW'($urandom_range(0, 3));
      x.used     = 2'($urandom);
      x.branch   = 1'($urandom);
      x.flush    = ($urandom_range(0, 9) == 0);
      x.clr      = ($urandom_range(0, 19) == 0);
      x.idex_rd  = RW'($urandom_range(0, 3));
      x.exmem_rd = RW'($urandom_range(0, 3));
      x.wb_rd    = RW'($urandom_range(0, 3));
      x.idex_rw  = 1'($urandom); x.idex_mr  = 1'($urandom);
      x.exmem_rw = 1'($urandom); x.exmem_mr = 1'($urandom);
      x.wb_rw    = 1'($urandom);
      drive(x);
    end

    // Reset asserted while in the STALL state drops stall at once.
    x = quiet();
    x.src0 = 2; x.used = 2'b01; x.branch = 1;
    x.idex_rd = 2; x.idex_rw = 1; x.idex_mr = 1;
    drive(x);
    @(negedge clk);
    apply(quiet());
    #3;
    check("stall_held_in_stall_state", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("stall_after_async_reset", 32'(stall), 32'd0);
    check("stall_cycles_after_async_reset", 32'(stall_cycles), 32'd0);
    stall_left = 0;
    sc_model   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(quiet());

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
